// File: rtl/button_pio_slave_if.sv
// Avalon-MM register bus between the Nios II data master and the pushbutton responder.
// Read data is registered by the responder and valid one clock after read.
interface button_pio_slave_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/button_pio_slave.sv
// Pushbutton PIO responder: synchronises and debounces active-low buttons, latches
// presses in a W1C edge-capture register and raises a maskable level interrupt.
module button_pio_slave #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                 SYS_CLK,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     pb_in,
  button_pio_slave_if.slave    bus,
  output logic                 irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  logic [WIDTH-1:0]            meta_q;
  logic [WIDTH-1:0]            sync_q;
  logic [WIDTH-1:0]            state_q;
  logic [WIDTH-1:0]            state_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            edge_q;
  logic [WIDTH-1:0]            edge_d;
  logic [WIDTH-1:0]            mask_q;
  logic [WIDTH-1:0]            mask_d;
  logic [WIDTH-1:0]            press;
  logic [WIDTH-1:0]            w1c;
  logic [WIDTH-1:0]            data_v;
  logic [WIDTH-1:0]            raw_v;
  logic [31:0]                 rdata_d;
  logic                        unused_wdata;

  // Only the low WIDTH bits of writedata carry register content.
  assign unused_wdata = ^bus.writedata;

  // Per-bit debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync_q[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press capture and register writes; a same-cycle press beats the W1C clear.
  always_comb begin
    press  = state_q & ~state_d;
    w1c    = '0;
    mask_d = mask_q;
    if (bus.write && (bus.address == ADDR_EDGE)) begin
      w1c = bus.writedata[WIDTH-1:0];
    end
    if (bus.write && (bus.address == ADDR_MASK)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~w1c) | press;
  end

  // Read mux samples pre-update register contents.
  always_comb begin
    data_v  = ~state_q;
    raw_v   = ~sync_q;
    rdata_d = '0;
    if (bus.read) begin
      case (bus.address)
        ADDR_DATA: rdata_d = 32'(data_v);
        ADDR_MASK: rdata_d = 32'(mask_q);
        ADDR_EDGE: rdata_d = 32'(edge_q);
        ADDR_RAW:  rdata_d = 32'(raw_v);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK or negedge reset_n) begin
    if (!reset_n) begin
      meta_q       <= '1;
      sync_q       <= '1;
      state_q      <= '1;
      cnt_q        <= '0;
      edge_q       <= '0;
      mask_q       <= '0;
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      meta_q       <= pb_in;
      sync_q       <= meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      edge_q       <= edge_d;
      mask_q       <= mask_d;
      bus.readdata <= rdata_d;
      irq          <= |(edge_q & mask_q);
    end
  end

endmodule

// File: tb/tb_button_pio_slave.sv
// Bench for button_pio_slave: directed corner sequences, a register-access vector table
// and randomized traffic, all checked against a behavioural sample-history model.
module tb_button_pio_slave;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] pb;
  logic       irq;
  int         checks   = 0;
  int         failures = 0;

  button_pio_slave_if bus ();

  button_pio_slave #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .SYS_CLK (clk),
    .reset_n (reset_n),
    .pb_in   (pb),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0]  m_p1, m_p2, m_st, m_ec, m_mask;
  logic [31:0] m_rd;
  logic        m_irq;
  logic [3:0]  m_hist[$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[12];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_p1   = '1;
    m_p2   = '1;
    m_st   = '1;
    m_ec   = '0;
    m_mask = '0;
    m_rd   = '0;
    m_irq  = 1'b0;
    m_hist.delete();
  endfunction

  // A level is accepted once the last D synchronised samples all disagree with it.
  function automatic void model_step();
    logic [3:0] st0, ec0, mk0, raw0, nst, clr;
    bit         all_diff;
    if (!reset_n) return;
    st0  = m_st;
    ec0  = m_ec;
    mk0  = m_mask;
    raw0 = m_p2;
    m_rd = '0;
    if (bus.read) begin
      case (bus.address)
        2'd0:    m_rd = {28'd0, ~st0};
        2'd1:    m_rd = {28'd0, mk0};
        2'd2:    m_rd = {28'd0, ec0};
        default: m_rd = {28'd0, ~raw0};
      endcase
    end
    m_hist.push_back(raw0);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    nst = st0;
    for (int b = 0; b < 4; b++) begin
      if (m_hist.size() == D) begin
        all_diff = 1'b1;
        for (int i = 0; i < m_hist.size(); i++)
          if (m_hist[i][b] == st0[b]) all_diff = 1'b0;
        if (all_diff) nst[b] = ~st0[b];
      end
    end
    m_st = nst;
    clr  = (bus.write && bus.address == 2'd2) ? bus.writedata[3:0] : 4'h0;
    m_ec = (ec0 & ~clr) | (st0 & ~nst);
    if (bus.write && bus.address == 2'd1) m_mask = bus.writedata[3:0];
    m_irq = |(ec0 & mk0);
    m_p2  = m_p1;
    m_p1  = pb;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_readdata", bus.readdata, m_rd);
    chk("model_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic drive(input logic [3:0] p, input bit rd, input bit wr,
                       input logic [1:0] a, input logic [31:0] wd);
    pb            = p;
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = wd;
  endtask

  task automatic idle(input int n, input logic [3:0] p);
    drive(p, 1'b0, 1'b0, 2'd0, 32'd0);
    repeat (n) tick();
  endtask

  task automatic read_chk(input logic [3:0] p, input logic [1:0] a,
                          input logic [31:0] exp, input string name);
    drive(p, 1'b1, 1'b0, a, 32'd0);
    tick();
    chk(name, bus.readdata, exp);
    drive(p, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic write_reg(input logic [3:0] p, input logic [1:0] a, input logic [31:0] wd);
    drive(p, 1'b0, 1'b1, a, wd);
    tick();
    drive(p, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic do_reset(input logic [3:0] p, input int n);
    drive(p, 1'b0, 1'b0, 2'd0, 32'd0);
    reset_n = 1'b0;
    model_reset();
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         hold;
    logic [3:0] cur;

    // Register-access vectors, pb_in held at 4'b1110 with EDGE=0x1 and IRQ_MASK=0xA beforehand
    vecs[0]  = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 2'd1, 32'hFFFFFFFF, 32'hA, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 32'h0,        32'hF, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 2'd2, 32'hFFFFFFF0, 32'h1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 2'd2, 32'h00000001, 32'h1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};

    reset_n = 1'b1;
    drive(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
    model_reset();
    #2;
    // Reset with all buttons held
    pb      = 4'h0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    drive(4'h0, 1'b1, 1'b0, 2'd0, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("reset_release_data", bus.readdata, (k > 6) ? 32'hF : 32'h0);
    end
    read_chk(4'h0, 2'd2, 32'hF, "reset_edge_capture");
    idle(8, 4'hF);
    read_chk(4'hF, 2'd2, 32'hF, "release_sets_nothing");
    write_reg(4'hF, 2'd2, 32'hF);
    read_chk(4'hF, 2'd2, 32'h0, "ec_cleared");

    // Glitch shorter than the debounce window
    idle(3, 4'b1101);
    idle(8, 4'hF);
    read_chk(4'hF, 2'd0, 32'h0, "glitch_data");
    read_chk(4'hF, 2'd2, 32'h0, "glitch_ec");

    // Held press qualifies after 2 + D clocks
    drive(4'b1101, 1'b1, 1'b0, 2'd0, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("debounce_data", bus.readdata, (k > 6) ? 32'h2 : 32'h0);
    end
    read_chk(4'b1101, 2'd2, 32'h2, "debounce_ec");
    idle(8, 4'hF);
    write_reg(4'hF, 2'd2, 32'h2);

    // Interrupt raise and W1C clear
    write_reg(4'hF, 2'd1, 32'h2);
    read_chk(4'hF, 2'd1, 32'h2, "mask_readback");
    drive(4'b1101, 1'b0, 1'b0, 2'd0, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("irq_after_press", 32'(irq), (k >= 7) ? 32'h1 : 32'h0);
    end
    drive(4'b1101, 1'b0, 1'b1, 2'd2, 32'h2);
    tick();
    chk("irq_at_w1c_edge", 32'(irq), 32'h1);
    drive(4'b1101, 1'b0, 1'b0, 2'd0, 32'd0);
    tick();
    chk("irq_after_w1c", 32'(irq), 32'h0);
    read_chk(4'b1101, 2'd2, 32'h0, "ec_after_w1c");
    idle(8, 4'hF);

    // Masked capture, then unmask
    idle(8, 4'b0111);
    read_chk(4'b0111, 2'd2, 32'h8, "masked_ec");
    chk("masked_irq", 32'(irq), 32'h0);
    drive(4'b0111, 1'b0, 1'b1, 2'd1, 32'hA);
    tick();
    chk("irq_unmask_edge", 32'(irq), 32'h0);
    drive(4'b0111, 1'b0, 1'b0, 2'd0, 32'd0);
    tick();
    chk("irq_unmasked", 32'(irq), 32'h1);
    write_reg(4'b0111, 2'd2, 32'h8);
    idle(1, 4'b0111);
    chk("irq_after_clear8", 32'(irq), 32'h0);
    idle(8, 4'hF);

    // W1C lands on the same edge as the debounced press
    idle(5, 4'b1110);
    drive(4'b1110, 1'b0, 1'b1, 2'd2, 32'h1);
    tick();
    idle(1, 4'b1110);
    read_chk(4'b1110, 2'd2, 32'h1, "collision_ec");
    read_chk(4'b1110, 2'd0, 32'h1, "collision_data");

    // Register-access vector table
    for (int i = 0; i < 12; i++) begin
      drive(4'b1110, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      tick();
      chk($sformatf("vec%0d_readdata", i), bus.readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Reset in the middle of a debounce window restarts qualification
    idle(8, 4'hF);
    idle(4, 4'b1011);
    do_reset(4'b1011, 2);
    drive(4'b1011, 1'b1, 1'b0, 2'd0, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("reset_requalify", bus.readdata, (k > 6) ? 32'h4 : 32'h0);
    end
    read_chk(4'b1011, 2'd2, 32'h4, "requalify_ec");

    // Randomized traffic against the model
    hold = 0;
    cur  = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        cur  = 4'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      if (n == 1500 || $urandom_range(0, 599) == 0) do_reset(cur, 2);
      drive(cur, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            2'($urandom), $urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_pio_slave.md
Name: button_pio_slave

Overview:
- Avalon-MM responder that the Nios II data master reads to sample the board pushbuttons. It replaces the generic PIO input path.
- Synchronises and debounces the active-low PB inputs, and latches press events in an edge-capture register.
- Raises a maskable level interrupt to the CPU.
- Sits inside the Qsys system, between the PB pins and the CPU's Avalon-MM interconnect.

Parameters:
- WIDTH, 4, number of pushbutton inputs.
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a new level (10 ms at 50 MHz). Must be >= 2. Counter width = $clog2(DEBOUNCE_CYCLES+1).

Ports:
- SYS_CLK  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- pb_in  input  WIDTH  raw pushbutton pins, asynchronous, active-low (0 = pressed).
- address  input  2  Avalon word address.
- read  input  1  Avalon read strobe.
- write  input  1  Avalon write strobe.
- writedata  input  32  Avalon write data.
- readdata  output  32  Avalon read data, fixed read latency 1.
- irq  output  1  level interrupt, active-high.

Behaviour:
- Reset (async assert, sync release by the system) sets:
  - sync FFs and debounced state to all 1s (released);
  - debounce counters, irq_mask, edge_capture, readdata and irq to 0.
- Synchroniser: 2-FF per bit on pb_in. Only the second stage (sync) feeds logic.
- Debounce, per bit, independent:
  - If sync == state, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and sync still differs, state <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES clocks never changes state.
  - Pin-to-state latency = 2 sync + DEBOUNCE_CYCLES clocks.
- Press detect: a bit is set when state goes 1->0. A release (0->1) sets nothing.
- Register map (word addresses):
  - 0 DATA: RO, bits[WIDTH-1:0] = ~state (1 = pressed). Writes ignored.
  - 1 IRQ_MASK: RW, bits[WIDTH-1:0]. Upper bits read 0, write-ignored.
  - 2 EDGE_CAPTURE: R/W1C. Bit set on press; cleared by writing 1 to that bit.
  - 3 RAW: RO, ~sync (undebounced, for diagnostics). Writes ignored.
- Avalon timing:
  - No waitrequest. Writes take effect at the clock edge on which write=1.
  - Read: readdata is registered and valid the cycle after read=1. It shows register contents as of the read cycle, before any same-cycle update.
  - readdata returns 0 in the cycle after a non-read cycle.
  - read and write asserted together: both are performed.
- Simultaneous press and W1C on the same bit in one cycle: set wins, the bit stays 1.
- irq = |(edge_capture & irq_mask), registered (1 clock after the source change).
  - irq stays asserted until the CPU clears all enabled captured bits or masks them.
- Multiple presses before the CPU clears a bit: the bit stays 1 and no count is kept.
- Reset mid-debounce: the counter is discarded. After release, a held button re-qualifies from scratch (full latency again).

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset: assert reset_n=0 with pb_in=4'b0000, then release. Required: readdata=0, irq=0, DATA reads 0x0 until 2+4 clocks after release, then reads 0xF. EDGE_CAPTURE=0xF, since all four debounced bits fall 1->0.
- Debounce: drive pb_in[1] low for 3 clocks then high. Required: DATA=0x0, EDGE_CAPTURE=0x0. Hold it low for 4 or more clocks: DATA=0x2 exactly 6 clocks after the falling edge, EDGE_CAPTURE=0x2.
- Interrupt: write IRQ_MASK=0x2, then press PB[1]. Required: irq=1 one clock after EDGE_CAPTURE bit1 sets. Write EDGE_CAPTURE=0x2: irq=0 the next clock and EDGE_CAPTURE reads 0x0.
- Masking: press PB[3] with IRQ_MASK=0x2. Required: EDGE_CAPTURE=0x8, irq=0. Write IRQ_MASK=0xA: irq=1 one clock later.
- Collision: time a W1C of 0x1 to the same cycle as the PB[0] debounced press. Required: EDGE_CAPTURE bit0 reads 1 afterwards.
- Read latency and read-only registers: issue a read at address 3 with pb_in=4'b1110 held. Required: readdata=0x1 one clock later and 0 the clock after. Write 0xFFFFFFFF to address 0: DATA unchanged.
